// File: rtl/irq_controller.sv
// irq_controller: synchronises, latches and masks NSRC interrupt lines and presents one vector at a time to the CPU.
// Build option IRQCTL_EDGE_EN: PEND latched on rising edges (W1C + ack clear); otherwise PEND follows the synchronised lines.
//   state | meaning
//   IDLE  | no request outstanding, looking for a winner
//   REQ   | IRQ high, vector held, waiting for IRQAck
//   INSVC | handler running, waiting for an EOI write
module irq_controller #(
    parameter int          NSRC       = 8,
    parameter logic [13:0] BASE_ADDR  = 14'h3F00,
    parameter int          VEC_STRIDE = 4,
    parameter logic [11:0] VEC_RESET  = 12'h010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [13:0]     dataAddress,
    input  logic [31:0]     dataOut,
    input  logic            dataWrEn,
    output logic [31:0]     regRdData,
    output logic            regHit,
    output logic            IRQ,
    output logic [11:0]     IRQn,
    input  logic            IRQAck,
    output logic [3:0]      inService,
    output logic            busy
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_INSVC} state_t;

    state_t          state;
    logic [NSRC-1:0] sync1, sync2, mask, pend;
    logic [11:0]     vbase, vec;
    logic [13:0]     off;
    logic            wr_mask, wr_pend, wr_eoi, wr_vbase;
    logic            win_any;
    logic [3:0]      win_idx;
    logic            unused_ok;

    assign off      = dataAddress - BASE_ADDR;
    assign regHit   = (off[13:2] == 12'd0);
    assign wr_mask  = dataWrEn && regHit && (off[1:0] == 2'd0);
    assign wr_pend  = dataWrEn && regHit && (off[1:0] == 2'd1);
    assign wr_eoi   = dataWrEn && regHit && (off[1:0] == 2'd2);
    assign wr_vbase = dataWrEn && regHit && (off[1:0] == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

`ifdef IRQCTL_EDGE_EN
    logic [NSRC-1:0] sync3, pend_clr, ack_clr;

    assign pend_clr  = wr_pend ? dataOut[NSRC-1:0] : '0;
    assign unused_ok = &{1'b0, dataOut};

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++)
            ack_clr[i] = (state == S_REQ) && IRQAck && (inService == 4'(i));
    end

    // A new edge beats a W1C on the same bit; the ack clear beats both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync3 <= '0;
            pend  <= '0;
        end else begin
            sync3 <= sync2;
            pend  <= ((pend & ~pend_clr) | (sync2 & ~sync3)) & ~ack_clr;
        end
    end
`else
    assign pend      = sync2;
    assign unused_ok = &{1'b0, dataOut, wr_pend};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask  <= '0;
            vbase <= VEC_RESET;
        end else begin
            if (wr_mask)
                mask <= dataOut[NSRC-1:0];
            if (wr_vbase)
                vbase <= dataOut[11:0];
        end
    end

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i] && mask[i]) begin
                win_any = 1'b1;
                win_idx = 4'(i);
            end
        end
    end

    assign vec = vbase + 12'(win_idx) * 12'(VEC_STRIDE);

    always_comb begin
        regRdData = '0;
        if (regHit) begin
            case (off[1:0])
                2'd0:    regRdData[NSRC-1:0] = mask;
                2'd1:    regRdData[NSRC-1:0] = pend;
                2'd3:    regRdData[11:0]     = vbase;
                default: regRdData           = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            IRQ       <= 1'b0;
            IRQn      <= '0;
            inService <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        state     <= S_REQ;
                        IRQ       <= 1'b1;
                        IRQn      <= vec;
                        inService <= win_idx;
                    end
                end
                S_REQ: begin
                    if (IRQAck) begin
                        IRQ   <= 1'b0;
                        state <= S_INSVC;
                    end
                end
                S_INSVC: begin
                    if (wr_eoi)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Randomised bench for irq_controller against a behavioural model of PEND/MASK/VBASE and the request handshake.
module tb_irq_controller;
    localparam int          NSRC = 8;
    localparam logic [13:0] BASE = 14'h3F00;
`ifdef IRQCTL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src;
    logic [13:0]     dataAddress;
    logic [31:0]     dataOut;
    logic            dataWrEn;
    logic [31:0]     regRdData;
    logic            regHit;
    logic            IRQ;
    logic [11:0]     IRQn;
    logic            IRQAck;
    logic [3:0]      inService;
    logic            busy;

    irq_controller #(.NSRC(NSRC)) dut (
        .clk(clk), .rst(rst), .src(src),
        .dataAddress(dataAddress), .dataOut(dataOut), .dataWrEn(dataWrEn),
        .regRdData(regRdData), .regHit(regHit),
        .IRQ(IRQ), .IRQn(IRQn), .IRQAck(IRQAck),
        .inService(inService), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: q[k] = src sampled k+1 edges ago; phase 0 idle, 1 waiting ack, 2 in service.
    bit [NSRC-1:0] q[3];
    bit [NSRC-1:0] m_pend, m_mask;
    int            m_vbase, m_phase, m_idx, m_vec;
    bit            m_irq;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) q[k] = '0;
        m_pend = '0; m_mask = '0; m_vbase = 'h010;
        m_phase = 0; m_idx = 0; m_vec = 0; m_irq = 1'b0;
    endtask

    function automatic bit [NSRC-1:0] pend_view();
        return EDGE ? m_pend : q[1];
    endfunction

    function automatic int lowest(input bit [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit in_window(input logic [13:0] a);
        logic [13:0] d;
        d = a - BASE;
        return d < 14'd4;
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] a);
        logic [13:0] d;
        logic [31:0] r;
        d = a - BASE;
        r = '0;
        case (d)
            14'd0:   r[NSRC-1:0] = m_mask;
            14'd1:   r[NSRC-1:0] = pend_view();
            14'd3:   r[11:0]     = 12'(m_vbase);
            default: r           = '0;
        endcase
        return r;
    endfunction

    task automatic model_edge(input bit [NSRC-1:0] s, input logic [13:0] a,
                              input logic [31:0] d, input bit we, input bit ack);
        logic [13:0]   dd;
        int            off, w, old_idx;
        bit            hit, ack_clear;
        bit [NSRC-1:0] np;
        dd = a - BASE;
        off = int'(dd);
        hit = (off < 4);
        w = lowest(pend_view() & m_mask);
        old_idx = m_idx;
        ack_clear = 1'b0;
        if (m_phase == 0) begin
            if (w >= 0) begin
                m_phase = 1; m_irq = 1'b1; m_idx = w;
                m_vec = (m_vbase + w * 4) % 4096;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_phase = 2; m_irq = 1'b0; ack_clear = 1'b1;
            end
        end else if (we && hit && off == 2) begin
            m_phase = 0;
        end
        np = m_pend;
        if (we && hit && off == 1) np &= ~d[NSRC-1:0];
        np |= q[1] & ~q[2];
        if (ack_clear) np[old_idx] = 1'b0;
        m_pend = EDGE ? np : '0;
        if (we && hit && off == 0) m_mask = d[NSRC-1:0];
        if (we && hit && off == 3) m_vbase = int'(d[11:0]);
        q[2] = q[1]; q[1] = q[0]; q[0] = s;
    endtask

    task automatic step();
        bit [NSRC-1:0] s;
        logic [13:0]   a;
        logic [31:0]   d;
        bit            we, ack;
        s = src; a = dataAddress; d = dataOut; we = dataWrEn; ack = IRQAck;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(s, a, d, we, ack);
        #1;
        check("IRQ",       IRQ,       32'(m_irq));
        check("IRQn",      IRQn,      32'(m_vec));
        check("inService", inService, 32'(m_idx));
        check("busy",      busy,      32'(m_phase != 0));
        check("regHit",    regHit,    32'(in_window(dataAddress)));
        check("regRdData", regRdData, model_read(dataAddress));
    endtask

    task automatic wr(input int o, input logic [31:0] d);
        dataAddress = BASE + 14'(o);
        dataOut = d;
        dataWrEn = 1'b1;
        step();
        dataWrEn = 1'b0;
        dataAddress = BASE + 14'd1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic ack_cycle();
        IRQAck = 1'b1;
        step();
        IRQAck = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        int k;
        k = 0;
        while (!m_irq && k < 40) begin
            step();
            k++;
        end
        check(tag, IRQ, 32'd1);
    endtask

    task automatic reset_check();
        #1 rst = 1'b1;
        #1 model_reset();
        check("rst_IRQ", IRQ, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_inService", inService, 32'd0);
        check("rst_IRQn", IRQn, 32'd0);
        for (int o = 0; o < 4; o++) begin
            dataAddress = BASE + 14'(o);
            #1 check("rst_reg", regRdData, model_read(dataAddress));
        end
        check("rst_vbase_val", 32'(m_vbase), 32'h010);
        dataAddress = BASE + 14'd1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int r;
        rst = 1'b1; src = '0; dataAddress = BASE + 14'd1; dataOut = '0;
        dataWrEn = 1'b0; IRQAck = 1'b0;
        model_reset();
        idle(2);
        rst = 1'b0;

        // single source, latency and vector
        wr(0, 32'h01);
        src = 8'h01;
        k = 0;
        while (!IRQ && k < 10) begin
            step();
            k++;
            if (k == 3) src = '0;
        end
        src = '0;
        check("latency", k, EDGE ? 32'd4 : 32'd3);
        check("vec_src0", IRQn, 32'h010);
        ack_cycle();
        check("ack_busy", busy, 32'd1);
        idle(2);
        wr(2, 32'h0);
        check("eoi_busy", busy, 32'd0);
        idle(2);

        // priority between two simultaneous sources
        wr(0, 32'hFF);
        src = 8'h24;
        wait_irq("irq_pair");
        check("pair_first_idx", inService, 32'd2);
        check("pair_first_vec", IRQn, 32'h018);
        ack_cycle();
        src = 8'h20;
        idle(3);
        wr(2, 32'h0);
        wait_irq("irq_pair2");
        check("pair_second_idx", inService, 32'd5);
        check("pair_second_vec", IRQn, 32'h024);
        ack_cycle();
        src = '0;
        idle(3);
        wr(2, 32'h0);
        idle(2);

        // masked pending, unmask, W1C against a simultaneous edge
        wr(0, 32'h00);
        src = 8'h08;
        idle(4);
        check("masked_pend", regRdData, 32'h08);
        check("masked_noirq", IRQ, 32'd0);
        wr(0, 32'h08);
        step();
        check("unmask_irq", IRQ, 32'd1);
        ack_cycle();
        src = '0;
        idle(3);
        wr(2, 32'h0);
        wr(0, 32'h00);
        idle(4);
        src = 8'h08;
        idle(2);
        wr(1, 32'h08);
        #1 check("w1c_vs_set", regRdData, 32'h08);
        wr(1, 32'h08);
        src = '0;
        idle(3);
        wr(1, 32'hFF);

        // vector wrap and EOI ignored while requesting
        wr(3, 32'hFFE);
        wr(0, 32'h02);
        src = 8'h02;
        wait_irq("irq_wrap");
        check("wrap_vec", IRQn, 32'h002);
        wr(2, 32'h0);
        idle(1);
        check("eoi_in_req_irq", IRQ, 32'd1);
        check("eoi_in_req_busy", busy, 32'd1);
        ack_cycle();
        src = '0;
        idle(3);
        wr(2, 32'h0);
        wr(3, 32'h010);

        // reset while in service
        wr(0, 32'h01);
        src = 8'h31;
        wait_irq("irq_pre_rst");
        ack_cycle();
        src = 8'h30;
        idle(3);
        check("pend_pre_rst", regRdData, 32'h30);
        reset_check();
        src = '0;
        idle(3);

        // source held through ack and EOI
        wr(0, 32'h10);
        src = 8'h10;
        wait_irq("irq_hold");
        check("hold_vec", IRQn, 32'h020);
        ack_cycle();
        idle(2);
        wr(2, 32'h0);
        step();
        check("rerequest", IRQ, 32'(EDGE ? 0 : 1));
        ack_cycle();
        src = '0;
        idle(3);
        wr(2, 32'h0);
        idle(2);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)
                src = src ^ (NSRC'(1) << $urandom_range(0, NSRC - 1));
            IRQAck = ($urandom_range(0, 3) == 0);
            dataWrEn = 1'b0;
            dataOut = $urandom;
            r = $urandom_range(0, 11);
            if (m_phase == 2 && r < 3) begin
                dataAddress = BASE + 14'd2; dataWrEn = 1'b1;
            end else if (r == 3) begin
                dataAddress = BASE; dataWrEn = 1'b1;
            end else if (r == 4) begin
                dataAddress = BASE + 14'd1; dataWrEn = 1'b1;
            end else if (r == 5) begin
                dataAddress = BASE + 14'd3; dataWrEn = 1'b1;
            end else if (r == 6) begin
                dataAddress = 14'($urandom_range(0, 16383)); dataWrEn = 1'b1;
            end else if (r == 7) begin
                dataAddress = BASE - 14'd1;
            end else if (r == 8) begin
                dataAddress = BASE + 14'd4;
            end else begin
                dataAddress = BASE + 14'($urandom_range(0, 3));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller that sits between up to `NSRC` peripheral interrupt lines and the CPU's `IRQ`/`IRQn`/`IRQAck` port. It synchronises and latches source requests, applies a software mask, and picks the lowest-numbered pending unmasked source. It presents one request at a time to the CPU and blocks further requests until software writes end-of-interrupt (EOI). Registers are on the CPU data bus (`dataAddress`/`dataOut`/`dataWrEn`); read data is muxed by the top level.

## Interface
- `NSRC`, 8: number of interrupt sources, 1..16.
- `BASE_ADDR`, 14'h3F00: word address of register 0; registers occupy `BASE_ADDR`..`BASE_ADDR+3`.
- `VEC_STRIDE`, 4: instruction-word spacing between consecutive source vectors.
- `VEC_RESET`, 12'h010: reset value of the vector base register.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `src` in NSRC: raw interrupt lines, asynchronous to `clk`.
- `dataAddress` in 14: CPU data address.
- `dataOut` in 32: CPU write data.
- `dataWrEn` in 1: CPU write strobe; one cycle per store.
- `regRdData` out 32: combinational read data for `dataAddress`; 0 when not hit.
- `regHit` out 1: combinational; `dataAddress` lies in the register window.
- `IRQ` out 1: interrupt request to the CPU; registered.
- `IRQn` out 12: vector address to the CPU; registered.
- `IRQAck` in 1: CPU acknowledge.
- `inService` out 4: index of the source being serviced; valid while `busy`.
- `busy` out 1: a request is outstanding or in service.

## Operation
- Registers, at word offsets from `BASE_ADDR`:
  - 0 MASK (RW, reset 0): bit i=1 enables source i.
  - 1 PEND (R; W1C, reset 0).
  - 2 EOI (W; read 0).
  - 3 VBASE (RW, [11:0], reset `VEC_RESET`).
  - Bits at or above `NSRC` read 0 and ignore writes.
- Each `src[i]` passes through a 2-flop synchroniser. With edge mode, a 0→1 transition on the synchronised line sets `PEND[i]`.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Winner: lowest i with `PEND[i] & MASK[i]`.
- FSM states:
  - IDLE: if a winner exists, go to REQ. On the same edge, `IRQ`<=1, `IRQn`<=`VBASE + i*VEC_STRIDE` (12-bit, wraps modulo 4096), and `inService`<=i.
  - REQ: hold `IRQ` and `IRQn` stable. On the first cycle `IRQAck`=1:
    - `IRQ`<=0;
    - clear `PEND[inService]` (this clear wins over a simultaneous new edge on that bit);
    - go to INSVC.
  - INSVC: `IRQ`=0 and no new requests. A write to EOI returns to IDLE, whatever the data value.
- `busy` = (state != IDLE).
- An EOI write in IDLE or REQ is ignored.
- Changing MASK while in REQ does not withdraw the request; the latched winner is serviced.
- Reset mid-operation: everything returns to reset values at once, and `IRQ` drops asynchronously.
- Reset values of outputs: `IRQ`=0, `IRQn`=0, `inService`=0, `busy`=0; MASK=0, PEND=0, VBASE=`VEC_RESET`, synchronisers all 0.

## Timing
- `src[i]` rises before clock edge E0. Then:
  - sync stage 1 at E0;
  - sync stage 2 at E1;
  - `PEND[i]`=1 at E2;
  - `IRQ`=1 at E3, given IDLE and unmasked.
- Request latency is therefore 4 edges.
- `IRQAck` seen high at edge A gives `IRQ`=0 at A. This means `IRQ` falls one cycle after the CPU raises `IRQAck`, as the CPU requires: it is frozen while `IRQ` is high and loads `pc` only on its first acked cycle.
- Register writes take effect on the edge where `dataWrEn`=1 and the address hits.
- The earliest next request is the edge after the EOI edge.
- `regRdData`/`regHit` are purely combinational, with no added latency.

## Configuration
- `IRQCTL_EDGE_EN` defined:
  - PEND bits are set by rising edges, as above, and stay set until acknowledged or cleared by W1C.
- Undefined:
  - sources are level-sensitive; `PEND` = synchronised `src` each cycle;
  - W1C writes have no effect;
  - the ack-time clear is skipped; the source must be cleared at the peripheral before EOI, otherwise it re-requests.
  - Latency becomes 3 edges (`IRQ` at E2).

## Test plan
- Reset, then MASK=0x01, pulse `src[0]` high for 3 cycles with VBASE=0x010 → `IRQ`=1 with `IRQn`=0x010, 4 edges after the rise. Ack → `IRQ`=0, PEND=0x00, `busy`=1. Write EOI → `busy`=0.
- MASK=0xFF, `src[5]` and `src[2]` rise together → `inService`=2, `IRQn`=0x018. After EOI → `inService`=5, `IRQn`=0x024.
- MASK=0x00, `src[3]` rises → PEND=0x08 and no `IRQ`. Write MASK=0x08 → `IRQ` on the following edge. Write PEND=0x08 (W1C) on the same cycle as a new `src[3]` edge → PEND bit stays set.
- VBASE=0xFFE, `src[1]` → `IRQn`=0x002 (wrap). EOI written while in REQ → ignored, still waiting for `IRQAck`.
- Assert `rst` while in INSVC with PEND=0x30 → `IRQ`=0, PEND=0, MASK=0, VBASE=0x010 immediately, before the next clock edge.
- Without `IRQCTL_EDGE_EN`: hold `src[4]` high through ack and EOI → a second request to vector `VBASE+16` on the edge after EOI.
